// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute sequencer: opcodes, FSM states and
// per-opcode execute latency.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Cycles the ALU needs before its result may be sampled.
    function automatic int op_latency(input logic [2:0] op, input int mul_lat, input int div_lat);
        case (op)
            OP_MUL:  return mul_lat;
            OP_DIV:  return div_lat;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle execute controller: IDLE -> EXEC -> WB -> RESP handshake sequencer.
// Optional ALU_OPSEQ_PERF_EN adds perf_ops / perf_busy counters.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DW      = 16,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [DW-1:0] req_a,
    input  logic [DW-1:0] req_b,
    input  logic          req_store,
    output logic [2:0]    alu_op,
    output logic          alu_sub,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    output logic          mem_write,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err
`ifdef ALU_OPSEQ_PERF_EN
    ,
    output logic [31:0]   perf_ops,
    output logic [31:0]   perf_busy
`endif
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          store_reg;

    logic accept;
    logic illegal_op;
    logic div_zero;

    always_comb begin
        accept     = req_valid && req_ready;
        illegal_op = (req_op[2:1] == 2'b11);
        div_zero   = (req_op == OP_DIV) && (req_b == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            store_reg <= 1'b0;
            req_ready <= 1'b1;
            alu_op    <= OP_ADD;
            alu_sub   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        store_reg <= req_store;
                        if (illegal_op || div_zero) begin
                            // Error ops never reach the ALU; the result is decided here.
                            rsp_err   <= 1'b1;
                            rsp_data  <= {DW{div_zero}};
                            state_reg <= ST_WB;
                        end else begin
                            rsp_err   <= 1'b0;
                            alu_op    <= req_op;
                            alu_sub   <= (req_op == OP_SUB);
                            alu_a     <= req_a;
                            alu_b     <= req_b;
                            cnt_reg   <= CW'(op_latency(req_op, MUL_LAT, DIV_LAT) - 1);
                            state_reg <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_reg == '0) begin
                        rsp_data  <= alu_result;
                        alu_sub   <= 1'b0;
                        mem_write <= store_reg;
                        state_reg <= ST_WB;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_WB: begin
                    rsp_valid <= 1'b1;
                    state_reg <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_OPSEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (state_reg != ST_IDLE)
                perf_busy <= perf_busy + 32'd1;
            if (state_reg == ST_RESP && rsp_ready)
                perf_ops <= perf_ops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus randomized ops
// against a spec-level reference model; a simple ALU stub answers alu_* lines.
module tb_alu_op_sequencer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          req_store;
    logic [2:0]    alu_op;
    logic          alu_sub;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic          mem_write;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
`ifdef ALU_OPSEQ_PERF_EN
    logic [31:0]   perf_ops;
    logic [31:0]   perf_busy;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int ops_done = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DW(DW), .MUL_LAT(4), .DIV_LAT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_store(req_store),
        .alu_op(alu_op), .alu_sub(alu_sub), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .mem_write(mem_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef ALU_OPSEQ_PERF_EN
        , .perf_ops(perf_ops), .perf_busy(perf_busy)
`endif
    );

    // ALU stub: combinational answer from whatever the sequencer drives.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'd0, 3'd1: alu_result = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
            3'd2:       alu_result = alu_a & alu_b;
            3'd3:       alu_result = alu_a | alu_b;
            3'd4:       alu_result = alu_a * alu_b;
            3'd5:       alu_result = (alu_b != 0) ? (alu_a / alu_b) : '1;
            default:    alu_result = '0;
        endcase
    end

    // Reference result straight from the opcode table, in 32-bit arithmetic then truncated.
    function automatic logic [DW-1:0] ref_result(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int unsigned ia, ib, r;
        ia = a; ib = b;
        case (op)
            3'd0: r = ia + ib;
            3'd1: r = ia - ib;
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia * ib;
            3'd5: r = (ib == 0) ? 32'hFFFF_FFFF : ia / ib;
            default: r = 0;
        endcase
        return r[DW-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, follow it to the response handshake.
    task automatic run_op(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic st, input int hold);
        logic          dz, err, seen;
        int            lat, wb_k, k;
        logic [DW-1:0] exp_d;
        dz    = (op == 3'd5) && (b == 0);
        err   = (op >= 3'd6) || dz;
        lat   = (op == 3'd4) ? 4 : (op == 3'd5) ? 8 : 1;
        exp_d = ref_result(op, a, b);
        wb_k  = err ? 1 : lat + 1;

        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_op = op; req_a = a; req_b = b; req_store = st;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1; seen = 1'b0;
        while (!seen && k <= 20) begin
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                check("req_ready_busy", 32'(req_ready), 32'd0);
                check("mem_write", 32'(mem_write), 32'((k == wb_k) && st && !err));
                if (!err && k <= lat) begin
                    check("alu_op", 32'(alu_op), 32'(op));
                    check("alu_sub", 32'(alu_sub), 32'(op == 3'd1));
                    check("alu_a", 32'(alu_a), 32'(a));
                    check("alu_b", 32'(alu_b), 32'(b));
                end
                @(negedge clk);
                k++;
            end
        end
        check("rsp_latency", 32'(k), err ? 32'd2 : 32'(lat + 2));
        check("alu_sub_resp", 32'(alu_sub), 32'd0);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", 32'(rsp_data), 32'(exp_d));
            check("hold_ready", 32'(req_ready), 32'd0);
            req_valid = 1'b1;
            req_op = 3'($urandom_range(0, 3));
            req_a = 16'($urandom);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", 32'(rsp_data), 32'(exp_d));
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("mem_write_resp", 32'(mem_write), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("rsp_valid_after", 32'(rsp_valid), 32'd0);
        ops_done++;
        $display("op=%0d a=%0h b=%0h store=%0b hold=%0d -> data=%0h err=%0b lat=%0d",
                 op, a, b, st, hold, exp_d, err, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]    rop;
        logic [DW-1:0] ra, rb;

        // Reset with a pending request; nothing may be accepted.
        rst_n = 1'b0; req_valid = 1'b1; req_op = 3'd0; req_a = 16'd1; req_b = 16'd2;
        req_store = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_sub", 32'(alu_sub), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
`ifdef ALU_OPSEQ_PERF_EN
        check("rst_perf_busy", perf_busy, 32'd0);
`endif

        // Directed cases.
        run_op(3'd0, 16'd5, 16'd3, 1'b1, 0);
        run_op(3'd1, 16'd3, 16'd5, 1'b0, 0);
        run_op(3'd4, 16'd7, 16'd6, 1'b0, 0);
        run_op(3'd5, 16'd9, 16'd0, 1'b1, 0);
        run_op(3'd6, 16'd9, 16'd4, 1'b1, 0);
        run_op(3'd0, 16'h1234, 16'h1111, 1'b0, 10);
        run_op(3'd5, 16'd100, 16'd7, 1'b1, 1);
        run_op(3'd7, 16'd1, 16'd1, 1'b0, 0);
        run_op(3'd2, 16'hF0F0, 16'h3C3C, 1'b1, 0);
        run_op(3'd3, 16'hF0F0, 16'h0F01, 1'b0, 2);
        run_op(3'd4, 16'hFFFF, 16'hFFFF, 1'b1, 0);

        // Randomized ops.
        for (int i = 0; i < 25; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            run_op(rop, ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a MUL discards it.
        req_op = 3'd4; req_a = 16'd3; req_b = 16'd3; req_store = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_alu_op", 32'(alu_op), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_mem_write", 32'(mem_write), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
`ifdef ALU_OPSEQ_PERF_EN
        ops_done = 0;
`endif
        run_op(3'd0, 16'd20, 16'd22, 1'b1, 0);
`ifdef ALU_OPSEQ_PERF_EN
        check("perf_ops", perf_ops, 32'(ops_done));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
